vga_out: RTL



---
 rtl/vga_pkg.sv | 54 +++++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/vga_out.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared timing defaults, pixel-byte field layout and colour
//               helpers for the vga_out display back-end.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_cnt_w = 10;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_h_sync_start = c_h_active + c_h_fp;
  localparam int c_h_sync_end   = c_h_sync_start + c_h_sync;

  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;
  localparam int c_v_sync_start = c_v_active + c_v_fp;
  localparam int c_v_sync_end   = c_v_sync_start + c_v_sync;

  localparam int c_px_w  = 8;
  localparam int c_r_msb = 7;
  localparam int c_r_lsb = 6;
  localparam int c_g_msb = 5;
  localparam int c_g_lsb = 4;
  localparam int c_b_msb = 3;
  localparam int c_b_lsb = 2;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t c_black = '{r: 2'b00, g: 2'b00, b: 2'b00};

  // Bits [1:0] of the pixel byte carry no colour and are dropped here.
  function automatic rgb_t byte_to_rgb(input logic [c_px_w-1:0] px);
    rgb_t c;
    c.r = px[c_r_msb:c_r_lsb];
    c.g = px[c_g_msb:c_g_lsb];
    c.b = px[c_b_msb:c_b_lsb];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous show-ahead FIFO; pointers carry one extra wrap bit
//               so full and empty are told apart without a separate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_out.sv
`default_nettype none
// ============================================================================
// Module      : vga_out
// Description : Pixel FIFO, 640x480@60 scan generator and registered VGA pins
//               with strobe/ack input handshake and frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_out
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int H_ACTIVE   = c_h_active,
  parameter int H_FP       = c_h_fp,
  parameter int H_SYNC     = c_h_sync,
  parameter int H_BP       = c_h_bp,
  parameter int V_ACTIVE   = c_v_active,
  parameter int V_FP       = c_v_fp,
  parameter int V_SYNC     = c_v_sync,
  parameter int V_BP       = c_v_bp
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [c_px_w-1:0] data_i,
  input  logic              stb_i,
  output logic              ack_i,
  output logic              frame_start_o,
  output logic [1:0]        vga_r,
  output logic [1:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              underflow_o
);

  localparam logic [c_cnt_w-1:0] c_h_act   = c_cnt_w'(H_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_h_last  = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [c_cnt_w-1:0] c_hs_beg  = c_cnt_w'(H_ACTIVE + H_FP);
  localparam logic [c_cnt_w-1:0] c_hs_end  = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_cnt_w-1:0] c_v_act   = c_cnt_w'(V_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_v_last  = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [c_cnt_w-1:0] c_vs_beg  = c_cnt_w'(V_ACTIVE + V_FP);
  localparam logic [c_cnt_w-1:0] c_vs_end  = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_cnt_w-1:0] r_sx;
  logic [c_cnt_w-1:0] r_sy;

  logic              w_active;
  logic              w_frame_start;
  logic              w_hs_n;
  logic              w_vs_n;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_pop;
  logic [c_px_w-1:0] w_rd_data;
  rgb_t              w_px_rgb;
  rgb_t              w_pin_rgb;

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (r_sx == c_h_last) begin
      r_sx <= '0;
      r_sy <= (r_sy == c_v_last) ? '0 : r_sy + 1'b1;
    end else begin
      r_sx <= r_sx + 1'b1;
    end
  end

  assign w_active      = (r_sx < c_h_act) && (r_sy < c_v_act);
  assign w_frame_start = (r_sx == '0) && (r_sy == '0);
  assign w_hs_n        = !((r_sx >= c_hs_beg) && (r_sx < c_hs_end));
  assign w_vs_n        = !((r_sy >= c_vs_beg) && (r_sy < c_vs_end));

  // ---------------------------------------------------------------------------
  // Handshake and FIFO. Both flags reflect pre-cycle occupancy, so a strobe
  // seen while full waits one cycle even when a pop frees a slot that edge.
  // ---------------------------------------------------------------------------
  assign w_accept = stb_i && !ack_i && !w_full;
  assign w_pop    = w_active && !w_empty;

  pixel_fifo #(
    .WIDTH (c_px_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_accept),
    .wr_data (data_i),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_px_rgb  = byte_to_rgb(w_rd_data);
  assign w_pin_rgb = w_pop ? w_px_rgb : c_black;

  // ---------------------------------------------------------------------------
  // Registered pins, all aligned to the same scan position
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_i         <= 1'b0;
      frame_start_o <= 1'b0;
      vga_r         <= 2'b00;
      vga_g         <= 2'b00;
      vga_b         <= 2'b00;
      vga_hs        <= 1'b1;
      vga_vs        <= 1'b1;
      underflow_o   <= 1'b0;
    end else begin
      ack_i         <= w_accept;
      frame_start_o <= w_frame_start;
      vga_r         <= w_pin_rgb.r;
      vga_g         <= w_pin_rgb.g;
      vga_b         <= w_pin_rgb.b;
      vga_hs        <= w_hs_n;
      vga_vs        <= w_vs_n;
      // A starved pixel at (0,0) keeps the flag set across the frame boundary.
      underflow_o   <= (w_active && w_empty) || (underflow_o && !w_frame_start);
    end
  end

endmodule
`default_nettype wire
